ddr3_axi_pattern_tester: RTL and testbench

- AXI4 master that sits directly upstream of the DDR3 AXI controller, driving its slave port in place of the DDR3 test core.
- Writes a deterministic pattern over a contiguous region using INCR bursts, then reads the region back and compares every beat.
- Reports pass/fail, a saturating error count and the first failing address for LED/UART debug.
- One burst in flight at a time; throughput is not a goal.

---
 rtl/ddr3_test_pkg.sv | 29 ++
 rtl/ddr3_beat_checker.sv | 44 ++++
 rtl/ddr3_axi_pattern_tester.sv | 201 ++++++++++++++++++++
 tb/tb_ddr3_axi_pattern_tester.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_test_pkg.sv
// Shared types, AXI constants and the test-pattern generator for the DDR3
// pattern tester and its status blocks.
package ddr3_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WA,
    S_WD,
    S_WB,
    S_RA,
    S_RD,
    S_DONE
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int               ERR_W   = 16;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  // Data carried by the beat at byte address addr. Operands are widened to
  // 64 bits so one function serves any ADDR_W/DATA_W up to 64; callers
  // truncate to their data width.
  function automatic logic [63:0] pattern(input logic [63:0] addr,
                                          input logic [63:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/ddr3_beat_checker.sv
// Per-beat fault detection plus the saturating error counter and the
// first-failing-address latch. Kept standalone so a status block can reuse it.
module ddr3_beat_checker
  import ddr3_test_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              clr,
  input  logic              ev_vld,
  input  logic [ADDR_W-1:0] ev_addr,
  input  logic [DATA_W-1:0] ev_data,
  input  logic [DATA_W-1:0] ev_exp,
  input  logic [1:0]        ev_resp,
  input  logic              ev_last,
  input  logic              ev_exp_last,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  logic beat_err;

  // Any combination of data, response and last faults is a single error.
  assign beat_err = ev_vld && ((ev_data != ev_exp) ||
                               (ev_resp != RESP_OKAY) ||
                               (ev_last != ev_exp_last));

  // Count errors (sticky at max) and remember where the first one happened.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (clr) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (beat_err) begin
      if (err_count == '0)     first_err_addr <= ev_addr;
      if (err_count != ERR_MAX) err_count     <= err_count + 1'b1;
    end
  end

endmodule

// File: rtl/ddr3_axi_pattern_tester.sv
// AXI4 master that writes an address-xor-seed pattern over a region in INCR
// bursts, reads it back and checks every beat. One burst in flight at a time.
module ddr3_axi_pattern_tester
  import ddr3_test_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                ID_W       = 4,
  parameter int                BURST_LEN  = 16,
  parameter int                NUM_BURSTS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic [DATA_W-1:0]   seed,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [1:0]          awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  output logic                arvalid,
  input  logic                arready,
  output logic [ID_W-1:0]     arid,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [1:0]          arburst,
  input  logic                rvalid,
  output logic                rready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast
);

  localparam int                BEAT_W      = $clog2(BURST_LEN) + 1;
  localparam int                BCNT_W      = $clog2(NUM_BURSTS) + 1;
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 4);

  state_t              state, nstate;
  logic [DATA_W-1:0]   seed_q;
  logic [ADDR_W-1:0]   burst_addr;
  logic [BCNT_W-1:0]   burst_cnt;
  logic [BEAT_W-1:0]   beat;
  logic [ADDR_W-1:0]   beat_addr;
  logic [DATA_W-1:0]   exp_data;
  logic                last_beat, last_burst, start_acc, idle_like;
  logic                ev_vld, ev_rd;
  logic                unused_ids;

  // Only ID 0 is ever issued, so returned IDs carry no information.
  assign unused_ids = ^{bid, rid};

  assign idle_like  = (state == S_IDLE) || (state == S_DONE);
  assign start_acc  = start && idle_like;
  assign beat_addr  = burst_addr + ADDR_W'({beat, 2'b00});
  assign exp_data   = DATA_W'(pattern(64'(beat_addr), 64'(seed_q)));
  assign last_beat  = (beat == BEAT_W'(BURST_LEN - 1));
  assign last_burst = (burst_cnt == BCNT_W'(NUM_BURSTS - 1));

  // Constant and address/data fields; only the valids/readies depend on state.
  assign awid    = '0;
  assign arid    = '0;
  assign awaddr  = burst_addr;
  assign araddr  = burst_addr;
  assign awlen   = 8'(BURST_LEN - 1);
  assign arlen   = 8'(BURST_LEN - 1);
  assign awburst = BURST_INCR;
  assign arburst = BURST_INCR;
  assign wstrb   = '1;
  assign wdata   = exp_data;
  assign wlast   = last_beat;

  assign busy = !idle_like;
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

  // State register; async reset drops every valid in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= nstate;
  end

  // Next-state and channel handshake outputs.
  always_comb begin
    nstate  = state;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) nstate = S_WA;
      S_WA: begin
        awvalid = 1'b1;
        if (awready) nstate = S_WD;
      end
      S_WD: begin
        wvalid = 1'b1;
        if (wready && last_beat) nstate = S_WB;
      end
      S_WB: begin
        bready = 1'b1;
        if (bvalid) nstate = last_burst ? S_RA : S_WA;
      end
      S_RA: begin
        arvalid = 1'b1;
        if (arready) nstate = S_RD;
      end
      S_RD: begin
        rready = 1'b1;
        // Exit on beat count, not rlast: an early rlast is only an error.
        if (rvalid && last_beat) nstate = last_burst ? S_DONE : S_RA;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Seed, burst address/counter and beat counter bookkeeping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seed_q     <= '0;
      burst_addr <= BASE_ADDR;
      burst_cnt  <= '0;
      beat       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          seed_q     <= seed;
          burst_addr <= BASE_ADDR;
          burst_cnt  <= '0;
          beat       <= '0;
        end
        S_WA: if (awready) beat <= '0;
        S_WD: if (wready)  beat <= beat + 1'b1;
        S_WB: if (bvalid) begin
          if (last_burst) begin
            burst_addr <= BASE_ADDR;
            burst_cnt  <= '0;
          end else begin
            burst_addr <= burst_addr + BURST_BYTES;
            burst_cnt  <= burst_cnt + 1'b1;
          end
        end
        S_RA: if (arready) beat <= '0;
        S_RD: if (rvalid) begin
          beat <= beat + 1'b1;
          if (last_beat) begin
            if (last_burst) begin
              burst_addr <= BASE_ADDR;
              burst_cnt  <= '0;
            end else begin
              burst_addr <= burst_addr + BURST_BYTES;
              burst_cnt  <= burst_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Write responses are checked per burst, read beats per beat; both feed
  // the same error bookkeeping so the count covers the whole pass.
  assign ev_rd  = (state == S_RD);
  assign ev_vld = ((state == S_WB) && bvalid) || (ev_rd && rvalid);

  ddr3_beat_checker #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_chk (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .clr           (start_acc),
    .ev_vld        (ev_vld),
    .ev_addr       (ev_rd ? beat_addr : burst_addr),
    .ev_data       (ev_rd ? rdata : '0),
    .ev_exp        (ev_rd ? exp_data : '0),
    .ev_resp       (ev_rd ? rresp : bresp),
    .ev_last       (ev_rd && rlast),
    .ev_exp_last   (ev_rd && last_beat),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

endmodule

// File: tb/tb_ddr3_axi_pattern_tester.sv
// Directed bench: behavioural AXI slave memory with fault injection and
// optional backpressure, plus a standalone checker for counter saturation.
module tb_ddr3_axi_pattern_tester;
  import ddr3_test_pkg::*;

  localparam int BL = 4;
  localparam int NB = 8;

  logic        CLK = 1'b0, RST_N = 1'b0, start = 1'b0;
  logic [31:0] seed = '0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [3:0]  awid, bid, arid, rid, wstrb;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;

  bit          bp = 0, flip_en = 0, slverr_en = 0, early_en = 0;
  logic [31:0] flip_addr = '0;

  int n_cmp = 0, n_bad = 0;

  always #5 CLK = ~CLK;

  ddr3_axi_pattern_tester #(.BURST_LEN(BL), .NUM_BURSTS(NB)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr),
    .awlen(awlen), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr),
    .arlen(arlen), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
    .rresp(rresp), .rlast(rlast)
  );

  // Standalone checker instance for the saturation scenario.
  logic        c_clr = 0, c_vld = 0, c_last = 0, c_exp_last = 0;
  logic [31:0] c_addr = '0, c_data = '0, c_exp = '0, c_first;
  logic [1:0]  c_resp = '0;
  logic [15:0] c_cnt;

  ddr3_beat_checker #(.ADDR_W(32), .DATA_W(32)) u_sat (
    .CLK(CLK), .RST_N(RST_N), .clr(c_clr), .ev_vld(c_vld), .ev_addr(c_addr),
    .ev_data(c_data), .ev_exp(c_exp), .ev_resp(c_resp), .ev_last(c_last),
    .ev_exp_last(c_exp_last), .err_count(c_cnt), .first_err_addr(c_first)
  );

  // ---------------- slave memory model ----------------
  logic [31:0] mem [0:31];
  logic [31:0] wa, ra;
  int          wcnt, rcnt;
  logic        ractive;

  assign bid = '0;
  assign rid = '0;

  function automatic int idx(input logic [31:0] a);
    return int'(a[6:2]);
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      awready <= 0; wready <= 0; arready <= 0; bvalid <= 0; bresp <= 0;
      rvalid <= 0; rdata <= 0; rresp <= 0; rlast <= 0; ractive <= 0;
      wa <= 0; ra <= 0; wcnt <= 0; rcnt <= 0;
    end else begin
      awready <= bp ? 1'($urandom_range(1)) : 1'b1;
      wready  <= bp ? 1'($urandom_range(1)) : 1'b1;
      arready <= bp ? 1'($urandom_range(1)) : 1'b1;
      if (awvalid && awready) begin wa <= awaddr; wcnt <= 0; end
      if (wvalid && wready) begin
        mem[idx(wa + 32'(wcnt * 4))] <= wdata;
        wcnt <= wcnt + 1;
        if (wlast) begin
          bvalid <= 1'b1;
          bresp  <= (slverr_en && wa[6:4] == 3'd2) ? 2'b10 : 2'b00;
        end
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin ra <= araddr; rcnt <= 0; ractive <= 1'b1; end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
        rcnt   <= rcnt + 1;
        if (rcnt == BL - 1) ractive <= 1'b0;
      end else if (ractive && !rvalid && (!bp || $urandom_range(1) == 1)) begin
        rvalid <= 1'b1;
        rdata  <= mem[idx(ra + 32'(rcnt * 4))] ^
                  ((flip_en && (ra + 32'(rcnt * 4)) == flip_addr) ? 32'd1 : 32'd0);
        rresp  <= 2'b00;
        rlast  <= (rcnt == BL - 1) || (early_en && ra[6:4] == 3'd0 && rcnt == 2);
      end
    end
  end

  // ---------------- handshake counters and stall-stability monitor ----------------
  int          aw_n = 0, w_n = 0, ar_n = 0, r_n = 0, viol = 0;
  logic        p_aw = 0, p_w = 0, p_ar = 0, p_wlast = 0;
  logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

  always @(posedge CLK) begin
    if (awvalid && awready) aw_n <= aw_n + 1;
    if (wvalid && wready)   w_n  <= w_n + 1;
    if (arvalid && arready) ar_n <= ar_n + 1;
    if (rvalid && rready)   r_n  <= r_n + 1;
    if (RST_N && ((p_aw && !(awvalid && awaddr == p_awaddr)) ||
                  (p_w  && !(wvalid && wdata == p_wdata && wlast == p_wlast)) ||
                  (p_ar && !(arvalid && araddr == p_araddr))))
      viol <= viol + 1;
    p_aw <= RST_N && awvalid && !awready; p_awaddr <= awaddr;
    p_w  <= RST_N && wvalid && !wready;   p_wdata  <= wdata; p_wlast <= wlast;
    p_ar <= RST_N && arvalid && !arready; p_araddr <= araddr;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a pass, check the one-cycle start-to-awvalid latency, optionally
  // poke start mid-pass, then wait (bounded) for done.
  task automatic run_pass(input logic [31:0] s, input string tag, input bit poke);
    @(negedge CLK); seed = s; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    chk({tag, "_lat_awvalid"}, awvalid, 1);
    chk({tag, "_busy"}, busy, 1);
    if (poke) begin
      repeat (20) @(negedge CLK);
      seed = 32'h0; start = 1'b1;
      @(negedge CLK); start = 1'b0;
    end
    for (int i = 0; i < 4000 && !done; i++) @(negedge CLK);
    chk({tag, "_done"}, done, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a0, w0, ar0, r0, v0;
    bit found;

    repeat (3) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_first", first_err_addr, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    RST_N = 1'b1;
    chk("const_burst", {awburst, arburst}, 4'b0101);
    chk("const_len", {awlen, arlen}, 16'h0303);
    chk("const_strb_id", {wstrb, awid, arid}, 12'hF00);

    // Ideal memory; a mid-pass start must be ignored.
    a0 = aw_n; w0 = w_n; ar0 = ar_n; r0 = r_n;
    run_pass(32'hA5A5_0000, "ideal", 1);
    chk("ideal_pass", pass, 1);
    chk("ideal_err", err_count, 0);
    chk("ideal_aw", aw_n - a0, NB);
    chk("ideal_w", w_n - w0, NB * BL);
    chk("ideal_ar", ar_n - ar0, NB);
    chk("ideal_r", r_n - r0, NB * BL);
    chk("ideal_mem24", mem[9], 32'hA5A5_0024);
    chk("ideal_mem7c", mem[31], 32'hA5A5_007C);
    repeat (5) @(negedge CLK);
    chk("done_held", {done, busy}, 2'b10);

    // Single bit flip on read data at 0x24.
    flip_en = 1; flip_addr = 32'h24;
    run_pass(32'hA5A5_0000, "flip", 0);
    chk("flip_err", err_count, 1);
    chk("flip_first", first_err_addr, 32'h24);
    chk("flip_pass", pass, 0);
    flip_en = 0;

    // Random backpressure on every channel.
    bp = 1; v0 = viol;
    a0 = aw_n; w0 = w_n; ar0 = ar_n; r0 = r_n;
    run_pass(32'hA5A5_0000, "bp", 0);
    chk("bp_pass", pass, 1);
    chk("bp_err", err_count, 0);
    chk("bp_stable", viol - v0, 0);
    chk("bp_beats", (w_n - w0) + (r_n - r0), 2 * NB * BL);
    chk("bp_addrs", (aw_n - a0) + (ar_n - ar0), 2 * NB);
    bp = 0;

    // SLVERR on the write response of burst 2.
    slverr_en = 1;
    run_pass(32'h1234_5678, "slverr", 0);
    chk("slverr_err", err_count, 1);
    chk("slverr_first", first_err_addr, 32'h20);
    chk("slverr_pass", pass, 0);
    slverr_en = 0;

    // Early rlast on beat 2 of burst 0; all 4 beats still consumed.
    early_en = 1; r0 = r_n;
    run_pass(32'hA5A5_0000, "early", 0);
    chk("early_err", err_count, 1);
    chk("early_first", first_err_addr, 32'h08);
    chk("early_r", r_n - r0, NB * BL);
    early_en = 0;

    // Async reset during the write data phase of burst 3.
    a0 = aw_n; found = 0;
    @(negedge CLK); seed = 32'hA5A5_0000; start = 1'b1;
    @(negedge CLK); start = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if ((aw_n - a0) == 4 && wvalid) found = 1;
      else @(negedge CLK);
    end
    chk("rst_reach_wd3", found, 1);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
    chk("rst_mid_busy", busy, 0);
    @(negedge CLK); RST_N = 1'b1;
    run_pass(32'hA5A5_0000, "after_rst", 0);
    chk("after_rst_pass", pass, 1);

    // Checker: multi-fault counts once, clean beat ignored, saturation.
    @(negedge CLK); c_clr = 1;
    @(negedge CLK); c_clr = 0;
    chk("sat_clr", c_cnt, 0);
    c_vld = 1; c_addr = 32'h100; c_data = 32'h1; c_exp = 32'h2; c_resp = 2'b10;
    c_last = 1; c_exp_last = 0;
    @(negedge CLK); c_vld = 0;
    chk("multi_fault_once", c_cnt, 1);
    chk("multi_fault_addr", c_first, 32'h100);
    c_vld = 1; c_addr = 32'h200; c_data = 32'h5; c_exp = 32'h5; c_resp = 2'b00;
    c_last = 1; c_exp_last = 1;
    @(negedge CLK); c_vld = 0;
    chk("clean_beat", c_cnt, 1);
    c_vld = 1; c_addr = 32'h300; c_last = 0;
    @(negedge CLK);
    chk("last_only_fault", c_cnt, 2);
    chk("first_kept", c_first, 32'h100);
    repeat (65532) @(negedge CLK);
    chk("sat_fffe", c_cnt, 16'hFFFE);
    @(negedge CLK);
    chk("sat_ffff", c_cnt, 16'hFFFF);
    repeat (70000 - 65535) @(negedge CLK);
    c_vld = 0;
    chk("sat_hold", c_cnt, 16'hFFFF);
    chk("sat_first", c_first, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
